// File: rtl/serial_to_parallel.sv
// serial_to_parallel: collects a frame of N-bit words from a valid/ready
// stream into a Length-entry parallel register bank. Entry 0 holds the first
// word of the frame. When the requested number of words has been taken, the
// block raises done_o and freezes the bank until the consumer acks.
//
// Build option: define S2P_ZERO_FILL_EN to clear the whole bank on every
// start_i, so unused entries read 0. With the macro undefined, only
// handshaked writes change bank entries, and stale data from earlier frames
// stays in entries the new frame does not reach.

module serial_to_parallel #(
   parameter int N      = 8,
   parameter int Length = 3
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             start_i,
   input  logic [$clog2(Length+1)-1:0]      collect_count_i,
   input  logic                             valid_i,
   input  logic [N-1:0]                     data_i,
   output logic                             ready_o,
   input  logic                             ack_i,
   output logic [Length-1:0][N-1:0]         store_o,
   output logic [$clog2(Length+1)-1:0]      count_o,
   output logic                             done_o
);

   localparam int CW = $clog2(Length + 1);
   localparam logic [CW-1:0] LEN_C = CW'(Length);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      FULL    = 2'd2
   } state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   pos_reg, pos_next;
   logic [CW-1:0]   target_reg, target_next;
   logic [CW-1:0]   target_clamped;
   logic            accept;
   logic            clear_bank;
   logic [Length-1:0] wr_en;

   // A requested count above the bank depth is clamped, so writes can never
   // land past entry Length-1.
   assign target_clamped = (collect_count_i > LEN_C) ? LEN_C : collect_count_i;

   // A word is only taken while collecting and not restarting; start_i wins
   // over a word presented in the same cycle.
   assign ready_o = (state_reg == COLLECT) && !start_i;
   assign accept  = valid_i && ready_o;
   assign done_o  = (state_reg == FULL);
   assign count_o = pos_reg;

`ifdef S2P_ZERO_FILL_EN
   // Every start wipes the bank so no data survives from a previous frame.
   assign clear_bank = start_i;
`else
   // Bank entries change only through handshaked writes.
   assign clear_bank = 1'b0;
`endif

   // State, position and target registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_reg  <= IDLE;
         pos_reg    <= '0;
         target_reg <= '0;
      end else begin
         state_reg  <= state_next;
         pos_reg    <= pos_next;
         target_reg <= target_next;
      end
   end

   // Next-state logic: start_i restarts from any state and beats ack_i.
   always_comb begin
      state_next  = state_reg;
      pos_next    = pos_reg;
      target_next = target_reg;
      if (start_i) begin
         target_next = target_clamped;
         pos_next    = '0;
         state_next  = (target_clamped != '0) ? COLLECT : FULL;
      end else begin
         case (state_reg)
            COLLECT: begin
               if (accept) begin
                  pos_next = pos_reg + 1'b1;
                  // target_reg is never 0 while collecting.
                  if (pos_reg == target_reg - 1'b1) begin
                     state_next = FULL;
                  end
               end
            end
            FULL: begin
               if (ack_i) begin
                  state_next = IDLE;
               end
            end
            default: begin
               state_next = state_reg;
            end
         endcase
      end
   end

   // One register per bank entry, written when the handshake addresses it.
   generate
      for (genvar gi = 0; gi < Length; gi++) begin : g_bank
         logic [N-1:0] store_reg;

         assign wr_en[gi] = accept && (pos_reg == CW'(gi));

         // Entry gi: reset/clear to 0, otherwise capture on its write slot.
         always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
               store_reg <= '0;
            end else if (clear_bank) begin
               store_reg <= '0;
            end else if (wr_en[gi]) begin
               store_reg <= data_i;
            end
         end

         assign store_o[gi] = store_reg;
      end
   endgenerate

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel. Main instance uses N=8, Length=3.
// A second instance uses Length=4, so a 3-bit count of 6 can exercise the
// clamp. Expected bank contents follow S2P_ZERO_FILL_EN when it is defined.

module tb_serial_to_parallel;

   logic        clk;
   logic        rst_n;

   // Instance A: N=8, Length=3.
   logic        a_start, a_valid, a_ack, a_ready, a_done;
   logic [1:0]  a_count_in, a_count;
   logic [7:0]  a_data;
   logic [2:0][7:0] a_store;

   // Instance B: N=8, Length=4.
   logic        b_start, b_valid, b_ack, b_ready, b_done;
   logic [2:0]  b_count_in, b_count;
   logic [7:0]  b_data;
   logic [3:0][7:0] b_store;

   int n_checks = 0;
   int n_errors = 0;

   serial_to_parallel #(.N(8), .Length(3)) dut_a (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .start_i         (a_start),
      .collect_count_i (a_count_in),
      .valid_i         (a_valid),
      .data_i          (a_data),
      .ready_o         (a_ready),
      .ack_i           (a_ack),
      .store_o         (a_store),
      .count_o         (a_count),
      .done_o          (a_done)
   );

   serial_to_parallel #(.N(8), .Length(4)) dut_b (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .start_i         (b_start),
      .collect_count_i (b_count_in),
      .valid_i         (b_valid),
      .data_i          (b_data),
      .ready_o         (b_ready),
      .ack_i           (b_ack),
      .store_o         (b_store),
      .count_o         (b_count),
      .done_o          (b_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   // Advance one edge; outputs are examined 1 ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one word with valid high and clock it in.
   task automatic a_word(input logic [7:0] d);
      a_valid = 1'b1;
      a_data  = d;
      step();
   endtask

   task automatic a_begin(input logic [1:0] cnt);
      a_start    = 1'b1;
      a_count_in = cnt;
      a_valid    = 1'b0;
      step();
      a_start    = 1'b0;
   endtask

   task automatic a_release();
      a_valid = 1'b0;
      a_ack   = 1'b1;
      step();
      a_ack   = 1'b0;
   endtask

   logic zf;

   initial begin
`ifdef S2P_ZERO_FILL_EN
      zf = 1'b1;
`else
      zf = 1'b0;
`endif
      rst_n = 1'b0;
      a_start = 0; a_count_in = 0; a_valid = 0; a_data = 0; a_ack = 0;
      b_start = 0; b_count_in = 0; b_valid = 0; b_data = 0; b_ack = 0;
      step();
      step();
      check_eq("reset done", a_done, 1'b0);
      check_eq("reset ready", a_ready, 1'b0);
      check_eq("reset count", a_count, 2'd0);
      check_eq("reset store", a_store, 24'h0);
      rst_n = 1'b1;

      // Frame of 3 with valid held high.
      a_begin(2'd3);
      a_valid = 1'b1; a_data = 8'h11;
      #1;
      check_eq("f1 ready in collect", a_ready, 1'b1);
      step();
      a_word(8'h22);
      check_eq("f1 done before last", a_done, 1'b0);
      a_word(8'h33);
      check_eq("f1 done", a_done, 1'b1);
      check_eq("f1 count", a_count, 2'd3);
      check_eq("f1 store", a_store, 24'h332211);
      check_eq("f1 ready in full", a_ready, 1'b0);
      a_word(8'h44);
      check_eq("f1 store held", a_store, 24'h332211);
      check_eq("f1 done held", a_done, 1'b1);
      a_release();
      check_eq("f1 idle after ack", a_done, 1'b0);
      check_eq("f1 count kept in idle", a_count, 2'd3);
      check_eq("f1 store kept in idle", a_store, 24'h332211);

      // Backpressure: count 2, valid 1,0,1.
      a_begin(2'd2);
      a_word(8'hA1);
      a_valid = 1'b0; a_data = 8'hFF;
      step();
      check_eq("bp count after gap", a_count, 2'd1);
      check_eq("bp done after gap", a_done, 1'b0);
      a_word(8'hB2);
      check_eq("bp done", a_done, 1'b1);
      check_eq("bp count", a_count, 2'd2);
      check_eq("bp store", a_store, zf ? 24'h00B2A1 : 24'h33B2A1);
      a_release();

      // Count 0: straight to FULL, no writes.
      a_begin(2'd0);
      check_eq("zero done", a_done, 1'b1);
      check_eq("zero count", a_count, 2'd0);
      check_eq("zero store", a_store, zf ? 24'h000000 : 24'h33B2A1);
      a_release();

      // Restart mid-frame after one word; the restart-cycle word is dropped
      // and ack during COLLECT is ignored.
      a_begin(2'd3);
      a_word(8'h5A);
      a_start = 1'b1; a_count_in = 2'd3; a_valid = 1'b1; a_data = 8'hEE;
      #1;
      check_eq("restart ready low", a_ready, 1'b0);
      step();
      a_start = 1'b0;
      check_eq("restart count", a_count, 2'd0);
      check_eq("restart done", a_done, 1'b0);
      a_ack = 1'b1;
      a_word(8'hC1);
      a_ack = 1'b0;
      check_eq("ack in collect ignored", a_count, 2'd1);
      a_word(8'hC2);
      a_word(8'hC3);
      check_eq("restart done final", a_done, 1'b1);
      check_eq("restart store", a_store, 24'hC3C2C1);
      a_release();

      // Reset during COLLECT.
      a_begin(2'd3);
      a_word(8'h77);
      a_valid = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check_eq("midrst done", a_done, 1'b0);
      check_eq("midrst ready", a_ready, 1'b0);
      check_eq("midrst count", a_count, 2'd0);
      check_eq("midrst store", a_store, 24'h0);
      a_word(8'h99);
      check_eq("idle valid ignored", a_store, 24'h0);
      a_valid = 1'b0;

      // Two frames: 3 words, then 1 word.
      a_begin(2'd3);
      a_word(8'hD1);
      a_word(8'hD2);
      a_word(8'hD3);
      a_release();
      a_begin(2'd1);
      a_word(8'hE1);
      a_valid = 1'b0;
      check_eq("two frames done", a_done, 1'b1);
      check_eq("two frames count", a_count, 2'd1);
      check_eq("two frames store", a_store, zf ? 24'h0000E1 : 24'hD3D2E1);
      a_release();

      // Clamp on the Length=4 instance: count 6 becomes 4.
      b_start = 1'b1; b_count_in = 3'd6;
      step();
      b_start = 1'b0;
      b_valid = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         b_data = 8'(i);
         step();
      end
      check_eq("clamp done after 3", b_done, 1'b0);
      check_eq("clamp count after 3", b_count, 3'd3);
      b_data = 8'h04;
      step();
      b_valid = 1'b0;
      check_eq("clamp done after 4", b_done, 1'b1);
      check_eq("clamp count", b_count, 3'd4);
      check_eq("clamp store", b_store, 32'h04030201);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
